// File: rtl/i2s_tx_serializer.sv
// ----------------------------------------------------------------------------
// i2s_tx_serializer
//
// Slave-mode I2S transmitter. The bit clock (bclk) and word select (lrclk)
// come from the audio clock generator and are sampled directly on clk; every
// serializer action happens on the clk edge that sees a bclk falling edge.
// Stereo pairs arrive over a valid/ready handshake into a one-entry holding
// buffer. The buffer is drained into the pair register at each left-slot
// start.
//
// Ports:
//   clk       system clock (bclk/lrclk are divided from it)
//   reset     asynchronous, active-high reset
//   enable    run enable; low forces IDLE (buffer and pair are kept)
//   bclk      bit clock, at least 4 clk per period
//   lrclk     word select: 0 = left slot, 1 = right slot
//   s_valid   sample pair valid
//   s_ready   holding buffer empty; pair accepted on s_valid & s_ready
//   s_left    left sample, DATA_W bits, MSB first on the line
//   s_right   right sample, DATA_W bits, MSB first on the line
//   sdata     serial data to the codec
//   underrun  one-clk pulse when a left slot starts with no pair buffered
//
// Parameter:
//   DATA_W    sample width per channel; slot bits beyond DATA_W are 0
//
// Build option:
//   I2S_TX_LEFT_JUSTIFIED_EN  when defined, the word MSB goes out on the
//   slot-start bclk fall itself (left-justified, no one-bit delay).
//   When undefined, standard I2S timing with the one-bit delay is used.
// ----------------------------------------------------------------------------
module i2s_tx_serializer #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              sdata,
    output logic              underrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              bclk_q;
    logic              lr_q, lr_d;
    logic              full_q, full_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] buf_l_q, buf_l_d;
    logic [DATA_W-1:0] buf_r_q, buf_r_d;
    logic [DATA_W-1:0] pair_l_q, pair_l_d;
    logic [DATA_W-1:0] pair_r_q, pair_r_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              sdata_q, sdata_d;
    logic              underrun_q, underrun_d;

    logic              bfall;
    logic              lr_chg;
    logic              left_start;
    logic              right_start;
    logic              accept;
    logic              drain;

    // Value placed in the shift register at a slot start. In left-justified
    // mode the MSB leaves on the load edge, so the register holds the rest.
    function automatic logic [DATA_W-1:0] slot_load(input logic [DATA_W-1:0] word);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        slot_load = word << 1'b1;
`else
        slot_load = word;
`endif
    endfunction

    assign bfall       = bclk_q & ~bclk;
    assign lr_chg      = bfall & (lrclk != lr_q);
    assign left_start  = lr_chg & ~lrclk;
    assign right_start = lr_chg & lrclk;
    // full_q is set only here and cleared only by a drain, so a handshake
    // can never coincide with the drain of the same entry.
    assign accept      = s_valid & ~full_q;

    // Next-state, datapath and output computation.
    always_comb begin
        state_d    = state_q;
        lr_d       = lr_q;
        full_d     = full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        pair_l_d   = pair_l_q;
        pair_r_d   = pair_r_q;
        shift_d    = shift_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        drain      = 1'b0;

        // lrclk is only meaningful at a bclk fall; track it there.
        if (bfall) begin
            lr_d = lrclk;
        end else begin
            lr_d = lr_q;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            sdata_d = 1'b0;
            shift_d = {DATA_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                    sdata_d = 1'b0;
                    shift_d = {DATA_W{1'b0}};
                end
                ST_SYNC: begin
                    // Right-slot edges are ignored until a frame begins.
                    if (left_start) begin
                        state_d = ST_RUN;
                        drain   = 1'b1;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_RUN: begin
                    // A load takes priority over the shift on the same bfall.
                    if (left_start) begin
                        drain = 1'b1;
                    end else if (right_start) begin
                        shift_d = slot_load(pair_r_q);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
                        sdata_d = pair_r_q[DATA_W-1];
`endif
                    end else if (bfall) begin
                        sdata_d = shift_q[DATA_W-1];
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    end else begin
                        shift_d = shift_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sdata_d = 1'b0;
                    shift_d = {DATA_W{1'b0}};
                end
            endcase
        end

        // Left-slot start: move the buffered pair into the pair register,
        // or send silence and flag the underrun when nothing is waiting.
        if (drain) begin
            if (full_q) begin
                pair_l_d = buf_l_q;
                pair_r_d = buf_r_q;
                full_d   = 1'b0;
            end else begin
                pair_l_d   = {DATA_W{1'b0}};
                pair_r_d   = {DATA_W{1'b0}};
                underrun_d = 1'b1;
            end
            shift_d = slot_load(pair_l_d);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
            sdata_d = pair_l_d[DATA_W-1];
`endif
        end else begin
            underrun_d = 1'b0;
        end

        if (accept) begin
            full_d  = 1'b1;
            buf_l_d = s_left;
            buf_r_d = s_right;
        end else begin
            buf_l_d = buf_l_q;
            buf_r_d = buf_r_q;
        end

        ready_d = ~full_d;
    end

    // State, datapath and output registers; reset discards any pending pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bclk_q     <= 1'b0;
            lr_q       <= 1'b0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            buf_l_q    <= {DATA_W{1'b0}};
            buf_r_q    <= {DATA_W{1'b0}};
            pair_l_q   <= {DATA_W{1'b0}};
            pair_r_q   <= {DATA_W{1'b0}};
            shift_q    <= {DATA_W{1'b0}};
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bclk_q     <= bclk;
            lr_q       <= lr_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            pair_l_q   <= pair_l_d;
            pair_r_q   <= pair_r_d;
            shift_q    <= shift_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_ready  = ready_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// ----------------------------------------------------------------------------
// Testbench for i2s_tx_serializer.
// The bench generates bclk (4 clk period) and lrclk (32 bits per slot) itself,
// so it knows the slot position of every bclk fall. A reference model keeps
// the buffered pair, the pair in flight and the expected line value derived
// from slot position, and pushes one expectation per clk into a queue; a
// separate monitor pops and compares sdata/underrun/s_ready.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

    localparam int DATA_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              bclk;
    logic              lrclk;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;
    logic              sdata;
    logic              underrun;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .sdata    (sdata),
        .underrun (underrun)
    );

    typedef struct {
        logic sd;
        logic ur;
        logic rdy;
        int   pos;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    exp_t  exp_q[$];
    pair_t pend_q[$];
    int    checks   = 0;
    int    failures = 0;

    // clock generator position: g_pos 0..31 left slot, 32..63 right slot
    int    g_cnt;
    int    g_pos;
    bit    g_fall;

    // reference model
    typedef enum {M_IDLE, M_WAIT, M_RUN} mmode_t;
    mmode_t            m_mode;
    logic              m_full;
    logic [DATA_W-1:0] m_bl, m_br, m_pl, m_pr;
    logic              m_sd, m_ur, m_acc;

    task automatic check(input string nm, input logic act, input logic req, input int pos);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s pos=%0d t=%0t got=%b want=%b", nm, pos, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_full = 1'b0;
        m_bl   = '0;
        m_br   = '0;
        m_pl   = '0;
        m_pr   = '0;
        m_sd   = 1'b0;
        m_ur   = 1'b0;
        m_acc  = 1'b0;
    endtask

    // Advance the model over the clk edge just passed, using the inputs that
    // were applied to it, and queue the outputs expected after that edge.
    task automatic model_step();
        logic              left_start;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] tmp;
        int                nb;
        if (reset) begin
            model_reset();
        end else begin
            m_acc      = s_valid && !m_full;
            m_ur       = 1'b0;
            left_start = g_fall && (g_pos == 0);
            if (!enable) begin
                m_mode = M_IDLE;
                m_sd   = 1'b0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_WAIT;
            end else if (left_start || (m_mode == M_RUN && g_fall)) begin
                if (left_start) begin
                    if (m_full) begin
                        m_pl   = m_bl;
                        m_pr   = m_br;
                        m_full = 1'b0;
                    end else begin
                        m_pl = '0;
                        m_pr = '0;
                        m_ur = 1'b1;
                    end
                    m_mode = M_RUN;
                end
                w  = (g_pos < 32) ? m_pl : m_pr;
                nb = (g_pos % 32) + 1;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
                if (nb <= DATA_W) begin
                    tmp  = w >> (DATA_W - nb);
                    m_sd = tmp[0];
                end else begin
                    m_sd = 1'b0;
                end
`else
                if (nb >= 2 && nb <= DATA_W + 1) begin
                    tmp  = w >> (DATA_W + 1 - nb);
                    m_sd = tmp[0];
                end else if (nb != 1) begin
                    m_sd = 1'b0;
                end
`endif
            end
            if (m_acc) begin
                m_full = 1'b1;
                m_bl   = s_left;
                m_br   = s_right;
            end
        end
        exp_q.push_back('{m_sd, m_ur, ~m_full, g_pos});
    endtask

    // One clk: model the edge just passed, then drive inputs for the next.
    task automatic cycle();
        pair_t p;
        @(negedge clk);
        model_step();
        if (s_valid && m_acc) begin
            p       = pend_q.pop_front();
            s_valid = 1'b0;
        end
        if (!s_valid && pend_q.size() > 0) begin
            s_valid = 1'b1;
            s_left  = pend_q[0].l;
            s_right = pend_q[0].r;
        end
        g_cnt++;
        g_fall = 1'b0;
        if (g_cnt % 4 == 2) begin
            g_fall = 1'b1;
            g_pos  = (g_pos + 1) % 64;
        end
        bclk  = (g_cnt % 4 < 2);
        lrclk = (g_pos >= 32);
    endtask

    task automatic run_to(input int pos);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(g_pos == pos && (g_cnt % 4) == 0) && n < 600);
    endtask

    task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        pend_q.push_back('{l, r});
    endtask

    // Monitor: compare every queued expectation shortly after the negedge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sdata", sdata, e.sd, e.pos);
                check("underrun", underrun, e.ur, e.pos);
                check("s_ready", s_ready, e.rdy, e.pos);
            end
        end
    end

    initial begin : driver
        int k;
        reset   = 1'b0;
        enable  = 1'b1;
        s_valid = 1'b0;
        s_left  = '0;
        s_right = '0;
        g_cnt   = 2;
        g_pos   = 60;
        g_fall  = 1'b0;
        bclk    = 1'b0;
        lrclk   = 1'b1;
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_sdata", sdata, 1'b0, -1);
        check("reset_underrun", underrun, 1'b0, -1);
        check("reset_s_ready", s_ready, 1'b1, -1);
        repeat (3) cycle();
        reset = 1'b0;

        // fixed pair, then a frame with nothing buffered
        push_pair(24'hA5A5A5, 24'h5A5A5A);
        run_to(40);
        run_to(40);

        // two pairs back to back with valid held
        push_pair(24'h123456, 24'hFEDCBA);
        push_pair(24'h800001, 24'h7FFFFE);
        run_to(40);
        run_to(40);
        run_to(40);

        // random traffic, sometimes none, sometimes two pairs
        for (int f = 0; f < 8; f++) begin
            run_to($urandom_range(41, 63));
            k = $urandom_range(0, 3);
            if (k != 0) push_pair(DATA_W'($urandom()), DATA_W'($urandom()));
            if (k == 3) push_pair(DATA_W'($urandom()), DATA_W'($urandom()));
            run_to(40);
        end

        // enable dropped mid left slot with a pair buffered, back in right slot
        push_pair(24'hC3C3C3, 24'h3C3C3C);
        run_to(40);
        run_to(2);
        push_pair(24'hF0F00F, 24'h0FF0F0);
        run_to(10);
        enable = 1'b0;
        run_to(40);
        enable = 1'b1;
        run_to(40);
        run_to(40);

        // reset at right-slot bit 10 with a pair buffered
        run_to(35);
        push_pair(24'h55AA55, 24'hAA55AA);
        run_to(41);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("midreset_sdata", sdata, 1'b0, g_pos);
        check("midreset_s_ready", s_ready, 1'b1, g_pos);
        check("midreset_underrun", underrun, 1'b0, g_pos);
        repeat (3) cycle();
        reset = 1'b0;
        push_pair(24'h0F1E2D, 24'hD2E1F0);
        run_to(40);
        run_to(40);

        repeat (2) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Slave-mode I2S transmitter. Consumes the bit clock and word-select clock produced by the audio clock generator and serializes stereo sample pairs onto one data line.
- Accepts left/right words over a valid/ready handshake into a one-entry holding buffer.
- Sits between the synth voice/mixer output and the codec DAC data pin, running on the same system clock that the bit and word clocks are divided from.

Parameters:
DATA_W, 24, sample word width per channel; MSB first; slot bits beyond DATA_W are driven 0

Ports:
clk  input  1  system clock; bclk/lrclk are derived from it and sampled directly
reset  input  1  asynchronous, active-high reset
enable  input  1  run enable; low forces IDLE
bclk  input  1  bit clock, at least 4 clk per period
lrclk  input  1  word select: 0 = left slot, 1 = right slot
s_valid  input  1  sample pair valid
s_ready  output  1  holding buffer empty; pair accepted when s_valid & s_ready
s_left  input  DATA_W  left sample
s_right  input  DATA_W  right sample
sdata  output  1  serial data to codec
underrun  output  1  one-clk pulse when a left slot starts with no pair buffered

Behaviour:
- Reset values: sdata=0, underrun=0, s_ready=1, holding buffer empty, shift register 0, state IDLE.
- Edge detection:
  - bclk_q registers bclk. bfall = bclk_q & ~bclk.
  - All serializer actions occur on the clk edge where bfall=1, so sdata lags the bclk falling edge by exactly 1 clk.
  - lrclk is sampled only at bfall into lr_q. lr_chg = (lrclk != lr_q) at bfall.
- Holding buffer:
  - One entry. s_ready = ~full. A handshake sets full and captures s_left/s_right.
  - It is drained only at a left-slot start. A handshake cannot occur in the drain cycle because s_ready is low then.
- FSM:
  - IDLE: sdata=0 and the shift register is cleared. When enable=1, go to SYNC.
  - SYNC: wait for bfall with lr_chg and lrclk=0 (left start), then go to RUN and perform a left load. Right-slot edges are ignored here.
  - RUN:
    - Left start: if buffer full, the pair register takes the buffer and full is cleared. Otherwise the pair register is zeroed and underrun pulses for this clk.
    - Shift register loads {left word, zero padding}.
    - Right start (lr_chg with lrclk=1): shift register loads {right word from the pair register, zero padding}.
    - Loading does not change sdata.
    - Every other bfall: sdata = shift MSB, then the shift register shifts left with 0 fill.
    - Result: MSB appears on the bclk fall one bit after the lrclk transition (standard I2S delay).
  - enable=0 in any state: IDLE on the next clk. sdata=0 on that clk. Holding buffer and pair register are retained. No underrun.
- Boundary cases:
  - Slot longer than DATA_W+1 bits: 0 padding.
  - Slot shorter: word truncated; the next lr_chg reloads.
  - lr_chg and bfall in the same clk are the normal case, so the load takes priority over the shift.
- Reset asserted mid-frame: all state returns to reset values immediately. The pending pair is discarded.

Optional Feature:
- Macro I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. At a slot-start bfall the word MSB is driven onto sdata in the same clk as the load, and the shift register loads the word already shifted by one. There is no one-bit delay.
- Undefined: standard I2S timing as described above.

Test Plan:
1. Bench stimulus: bclk period 4 clk, lrclk half-period 128 clk (32 bits/slot), enable=1. Push left=0xA5A5A5, right=0x5A5A5A. Required response: bits 2..25 after the lrclk fall are 0xA5A5A5 MSB first, and bits 26..32 are 0. The right slot carries 0x5A5A5A with the same alignment. No underrun.
2. No s_valid before a left start -> underrun high exactly 1 clk on that bfall. sdata is 0 for the entire frame.
3. Present pairs P1, P2 back-to-back with s_valid held high. Required response:
   - s_ready drops after P1 is accepted.
   - P1 drains at the next left start, and P2 is accepted on the following clk.
   - P1 and P2 are serialized in order with no underrun.
4. Deassert enable mid left slot -> sdata=0 on the next clk, FSM in IDLE. Reassert during the right slot -> sdata stays 0 until the next lrclk fall. The retained buffered pair is sent then.
5. Assert reset at bit 10 of the right slot -> sdata=0, s_ready=1, and the buffer is empty the same clk. After release, the block resumes only at the next left start.
6. With I2S_TX_LEFT_JUSTIFIED_EN defined, repeat test 1 -> 0xA5A5A5 occupies bits 1..24 of each slot, and bits 25..32 are 0.
